serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
- Bit-serial add/subtract sequencer. It time-shares one 1-bit full-adder/full-subtractor cell across a WIDTH-bit operation, processing one bit per clock, LSB first.
- Accepts a start request with two operands and an op select. Returns a registered result plus a carry-out/borrow-out flag.
- Sits between a requesting controller and the single-bit arithmetic cell. It trades area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  single-cycle pulse; result/cout valid.
- result  output  WIDTH  sum or difference; registered, held until next completion.
- cout  output  1  carry-out (add) or borrow-out (sub); held with result.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high.
  - On rst: state=IDLE, busy=0, done=0, result=0, cout=0. Internal shift registers, counter and carry flop are cleared.
  - rst asserted mid-operation aborts it; no done pulse is issued.
- States:
  - IDLE: if start=1, load a_sh<=a, b_sh<=b, op_r<=op, cy<=0, cnt<=0, go to SHIFT. Otherwise stay.
  - SHIFT: busy=1. Each edge:
    - Cell evaluates (a_sh[0], b_sh[0], cy, op_r).
    - r_sh shifts right with the cell's sum/diff bit inserted at the MSB.
    - a_sh and b_sh shift right; cy<=cell carry/borrow; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: result<=final r_sh value including this bit, cout<=cell carry/borrow, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. Next edge goes to IDLE unconditionally.
- Latency: start sampled at edge k; done is high in the cycle following edge k+WIDTH. Back-to-back issue is possible from edge k+WIDTH+2.
- Cell function:
  - add: s=a^b^c, co=ab|bc|ac.
  - sub: d=a^b^c, bo=(~a)b|bc|c(~a).
- Arithmetic is modulo 2^WIDTH.
  - cout=1 on unsigned carry (add) or when b+borrow_in exceeds a (sub, i.e. a<b unsigned).
- Boundary conditions:
  - start while busy or in DONE is ignored (not queued).
  - op/a/b changing during SHIFT has no effect.
  - result and cout never change except at completion or reset.
  - start held high continuously yields back-to-back operations, each accepted in IDLE.

Optional Feature:
- Macro SERIAL_ADDSUB_OVF_EN.
- When defined: extra output ovf (1 bit, reset 0) is registered at completion alongside cout. It is the two's-complement signed overflow, computed as carry-into-MSB XOR carry/borrow-out-of-MSB of the final bit step.
- When undefined: no ovf port, and no extra flop.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, addsub_bit_cell: purely combinational 1-bit full adder/full subtractor with op select. Inputs a, b, cin, op; outputs s, cout.
- The controller instantiates exactly one addsub_bit_cell.

Test Plan:
- Add: a=0x3C, b=0x55, op=0, start at edge k -> busy high for 8 cycles; done at cycle after edge k+8; result=0x91, cout=0.
- Add wrap: a=0xFF, b=0x01, op=0 -> result=0x00, cout=1; with SERIAL_ADDSUB_OVF_EN, ovf=0. Separate run a=0x7F, b=0x01 -> result=0x80, ovf=1.
- Subtract: a=0x10, b=0x20, op=1 -> result=0xF0, cout(borrow)=1. Then a=0x55, b=0x55 -> result=0x00, cout=0.
- Start during busy: pulse start with a=0x01, b=0x01 at cycle 3 of an ongoing op -> ignored; only one done pulse; result matches the first operation.
- Reset mid-op: assert rst at cycle 4 of SHIFT -> next cycle busy=0, done=0, result=0, cout=0; no done pulse. A fresh start then completes correctly.
- Continuous start=1 with fixed operands -> done pulses every WIDTH+2 cycles; result stable between pulses.

Source files
------------

// File: rtl/serial_addsub_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl_pkg
// Shared definitions for the bit-serial add/subtract sequencer:
//   - state_t : controller state encoding (IDLE / SHIFT / DONE)
//   - OP_ADD / OP_SUB : op select encoding used by the controller and the cell
// -----------------------------------------------------------------------------
package serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_ctrl_bit_cell.sv
// -----------------------------------------------------------------------------
// addsub_bit_cell
// Purely combinational 1-bit full adder / full subtractor.
// Ports:
//   a, b  : operand bits
//   cin   : carry-in (add) or borrow-in (sub)
//   op    : OP_ADD computes a+b+cin, OP_SUB computes a-b-cin
//   s     : sum / difference bit
//   cout  : carry-out (add) or borrow-out (sub)
// -----------------------------------------------------------------------------
module addsub_bit_cell
  import serial_addsub_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic op,
  output logic s,
  output logic cout
);

  // Sum and difference bits are the same XOR; only the carry/borrow differs.
  assign s = a ^ b ^ cin;

  always_comb begin
    if (op == OP_ADD) begin
      cout = (a & b) | (b & cin) | (a & cin);
    end else begin
      cout = (~a & b) | (b & cin) | (cin & ~a);
    end
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
// Bit-serial add/subtract sequencer. One addsub_bit_cell is time-shared over a
// WIDTH-bit operation, one bit per clock, LSB first.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds the signed overflow output.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request; sampled only in IDLE
//   op     : 0 = a+b, 1 = a-b; sampled with start
//   a, b   : WIDTH-bit operands; sampled with start
//   busy   : high while bits are processed (SHIFT)
//   done   : one-cycle pulse, result/cout valid
//   result : registered sum/difference, held until next completion
//   cout   : carry-out (add) / borrow-out (sub), held with result
//   ovf    : (SERIAL_ADDSUB_OVF_EN only) two's-complement overflow
// Handshake: start is a request accepted on any rising edge where the
// controller is in IDLE; requests while busy or done are dropped, not queued.
// done pulses for exactly one cycle and result/cout/ovf stay valid until the
// next completion or reset.
// -----------------------------------------------------------------------------
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Current controller state; kept as a named enum so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  logic             op_r;

  logic             cell_s;
  logic             cell_co;
  logic             last_bit;
  logic [WIDTH-1:0] r_next;

  addsub_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (cy),
    .op   (op_r),
    .s    (cell_s),
    .cout (cell_co)
  );

  assign last_bit = (cnt == CNT_LAST);
  // The new bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
  assign r_next   = {cell_s, r_sh[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: operand shifters, bit counter, carry flop and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      op_r   <= OP_ADD;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            op_r <= op;
            cy   <= 1'b0;
            cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          cy   <= cell_co;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            result <= r_next;
            cout   <= cell_co;
`ifdef SERIAL_ADDSUB_OVF_EN
            // cy is the carry/borrow into the MSB during the final step.
            ovf    <= cy ^ cell_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_ctrl
// Self-checking bench for serial_addsub_ctrl (WIDTH = 8). Expected values come
// from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         op_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // {ovf, cout, result} per accepted operation
  logic [W+1:0] exp_q[$];

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_in),
    .a      (a_in),
    .b      (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic o);
    int unsigned xi, yi, r;
    logic [W-1:0] res;
    logic c, v;
    xi = x;
    yi = y;
    if (o == 1'b0) begin
      r   = xi + yi;
      c   = (r >= (1 << W));
      res = r[W-1:0];
      v   = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
    end else begin
      r   = (xi - yi) & ((1 << W) - 1);
      c   = (xi < yi);
      res = r[W-1:0];
      v   = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
    end
    return {v, c, res};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_result(input string tag, input logic [W+1:0] e);
    check({tag, "_result"}, 32'(result), 32'(e[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDSUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
  endtask

  // ---------------- driver ----------------
  // Issues one operation and checks the full busy/done timeline. Inputs are
  // scrambled during SHIFT; at cycle `poke` a stray start (a=b=1) is pulsed.
  task automatic run_op(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic o, input int poke);
    logic [W+1:0] e;
    @(negedge clk);
    a_in  = x;
    b_in  = y;
    op_in = o;
    start = 1'b1;
    exp_q.push_back(model(x, y, o));
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == poke) begin
        start = 1'b1;
        a_in  = 8'h01;
        b_in  = 8'h01;
      end else begin
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        op_in = 1'($urandom_range(0, 1));
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_result(tag, e);
    // Idle afterwards: no further done, result held
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    end
    check_result({tag, "_held"}, e);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W+1:0] e;
    int t;
    int gap;
    rst   = 1'b1;
    start = 1'b0;
    op_in = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_result("rst", '0);
    rst = 1'b0;

    // Directed vectors
    run_op("add",      8'h3C, 8'h55, 1'b0, -1);
    run_op("add_wrap", 8'hFF, 8'h01, 1'b0, -1);
    run_op("add_ovf",  8'h7F, 8'h01, 1'b0, -1);
    run_op("sub_neg",  8'h10, 8'h20, 1'b1, -1);
    run_op("sub_zero", 8'h55, 8'h55, 1'b1, -1);
    run_op("sub_ovf",  8'h80, 8'h01, 1'b1, -1);

    // Stray start during SHIFT is ignored
    run_op("poke", 8'hA5, 8'h3C, 1'b0, 2);

    // Reset in the middle of SHIFT aborts without a done pulse
    @(negedge clk);
    a_in  = 8'h12;
    b_in  = 8'h34;
    op_in = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check_result("abort", '0);
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'd0);
    end
    run_op("after_rst", 8'hC8, 8'h64, 1'b0, -1);

    // Randomized operations
    for (int n = 0; n < 16; n++) begin
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), -1);
    end

    // Continuous start: done every W+2 cycles, result stable between pulses
    @(negedge clk);
    a_in  = 8'h9A;
    b_in  = 8'h47;
    op_in = 1'b1;
    start = 1'b1;
    e = model(8'h9A, 8'h47, 1'b1);
    t = 0;
    while (done !== 1'b1 && t < 4 * W) begin
      @(negedge clk);
      t++;
    end
    check("cont_first_done", 32'(done), 32'd1);
    check("cont_first_lat", 32'(t), 32'(W + 1));
    for (int p = 0; p < 3; p++) begin
      check_result("cont", e);
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
        if (done !== 1'b1) begin
          check("cont_stable", 32'(result), 32'(e[W-1:0]));
        end
      end while (done !== 1'b1 && gap < 4 * W);
      check("cont_gap", 32'(gap), 32'(W + 2));
    end
    check_result("cont_last", e);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("cont_stop_done", 32'(done), 32'd0);
    check("cont_stop_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
